// File: rtl/window_xy_ctrl_if.sv
// Pixel-stream and window-output handshake bundle for window_xy_ctrl.
// The controller side uses the slave modport; the stream source/sink uses master.
interface window_xy_ctrl_if #(
  parameter int CW = 10,
  parameter int RW = 9
) ();
  logic          in_valid;
  logic          in_ready;
  logic          win_clken;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;

  modport master (
    output in_valid, out_ready,
    input  in_ready, win_clken, out_valid, out_col, out_row
  );

  modport slave (
    input  in_valid, out_ready,
    output in_ready, win_clken, out_valid, out_col, out_row
  );
endinterface

// File: rtl/window_xy_ctrl.sv
// Sequencer for the left-image disparity window shift register: gates the
// window shift, tracks row/column and presents the window as a held output stage.
module window_xy_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int WIN_DEPTH  = 258,
  parameter int ROW_GAP    = 4,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  window_xy_ctrl_if.slave  bus,
  output logic             row_done,
  output logic             frame_done,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int GW = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;

  localparam logic [CW-1:0] LAST_COL   = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] FIRST_FULL = CW'(WIN_DEPTH - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(IMG_HEIGHT - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(ROW_GAP - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic          row_done_q, row_done_d;
  logic          frame_done_q, frame_done_d;

  logic abort_act;
  logic in_ready;
  logic accept;

  // The window itself is the output register, so a shift must wait until any
  // unconsumed window has been taken.
  assign abort_act = abort & (state_q != S_IDLE);
  assign in_ready  = (state_q == S_RUN) & ~abort_act & (~out_valid_q | bus.out_ready);
  assign accept    = bus.in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    gap_d        = gap_q;
    out_valid_d  = out_valid_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;

    if (out_valid_q & bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          col_d   = '0;
          row_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          out_col_d   = col_q;
          out_row_d   = row_q;
          // Column restarts every row, so stale pixels of the previous row never qualify.
          out_valid_d = (col_q >= FIRST_FULL);
          if (col_q == LAST_COL) begin
            col_d      = '0;
            row_done_d = 1'b1;
            if (row_q == LAST_ROW) begin
              state_d = S_DRAIN;
            end else begin
              row_d   = row_q + 1'b1;
              gap_d   = GAP_LOAD;
              state_d = S_GAP;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_RUN;
        else             gap_d   = gap_q - 1'b1;
      end
      S_DRAIN: begin
        if (~out_valid_q | bus.out_ready) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_act) begin
      state_d      = S_IDLE;
      out_valid_d  = 1'b0;
      col_d        = '0;
      row_d        = '0;
      gap_d        = '0;
      row_done_d   = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      gap_q        <= '0;
      out_valid_q  <= 1'b0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      gap_q        <= gap_d;
      out_valid_q  <= out_valid_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.win_clken = accept;
  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_row   = out_row_q;
  assign row_done      = row_done_q;
  assign frame_done    = frame_done_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_window_xy_ctrl.sv
// Directed bench for window_xy_ctrl on a 300x2 frame: scoreboard of expected
// window positions plus checks of backpressure, abort, start and async reset.
module tb_window_xy_ctrl;
  localparam int W  = 300;
  localparam int H  = 2;
  localparam int D  = 258;
  localparam int G  = 2;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic clock = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic row_done, frame_done, busy;

  window_xy_ctrl_if #(.CW(CW), .RW(RW)) ifc ();

  window_xy_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .WIN_DEPTH(D), .ROW_GAP(G)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .abort(abort),
    .bus(ifc.slave), .row_done(row_done), .frame_done(frame_done), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int sb_q[$];
  int mcol = 0, mrow = 0, cyc = 0, last_acc = 0, gap_len = -1;
  int n_out = 0, n_clk = 0, n_rd = 0, n_fd = 0;
  int first_col = -1, first_row = -1, last_col = -1;
  bit got_first = 1'b0;
  bit prev_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_out = 0; n_clk = 0; n_rd = 0; n_fd = 0;
    got_first = 1'b0; first_col = -1; first_row = -1; last_col = -1; gap_len = -1;
  endtask

  // Reference model: accepted pixels advance a column/row counter; every
  // accepted pixel at column >= D-1 must later appear as a window output.
  always @(negedge clock) begin
    bit acc;
    int e;
    cyc++;
    if (rst) begin
      sb_q.delete();
      mcol = 0; mrow = 0; prev_last = 1'b0;
    end else begin
      acc = ifc.in_valid && ifc.in_ready;
      chk("win_clken", ifc.win_clken, acc);
      chk("row_done_timing", row_done, prev_last);
      if (row_done)   n_rd++;
      if (frame_done) n_fd++;
      if (ifc.out_valid && ifc.out_ready) begin
        n_out++;
        if (!got_first) begin
          got_first = 1'b1; first_col = ifc.out_col; first_row = ifc.out_row;
        end
        last_col = ifc.out_col;
        if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
        else begin
          e = sb_q.pop_front();
          chk("out_col", ifc.out_col, e % 1024);
          chk("out_row", ifc.out_row, e / 1024);
        end
      end
      prev_last = acc && (mcol == W - 1);
      if (acc) begin
        n_clk++;
        if (mcol >= D - 1) sb_q.push_back(mrow * 1024 + mcol);
        if (mcol == W - 1) begin
          last_acc = cyc; mcol = 0; mrow++;
        end else begin
          if (mcol == 0 && mrow > 0) gap_len = cyc - last_acc;
          mcol++;
        end
      end
      if (abort && busy) begin
        sb_q.delete(); mcol = 0; mrow = 0;
      end
      if (start && !busy) begin
        mcol = 0; mrow = 0;
      end
    end
  end

  // One frame: pct = % of cycles with in_valid low; bp_col/ab_col/rs_col >= 0
  // trigger backpressure, abort (row 0) or async reset (row 1) at that column.
  task automatic frame(input int pct, input int bp_col, input int ab_col,
                       input int rs_col, input bit poke_start);
    int bp_left;
    bit bp_done;
    bit fin;
    bp_left = 0; bp_done = 1'b0; fin = 1'b0;
    @(posedge clock); #1;
    start = 1'b1; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    for (int i = 0; i < 4000 && !fin; i++) begin
      @(posedge clock); #1;
      start = poke_start && (i == 100 || row_done);
      if (frame_done) begin
        fin = 1'b1;
      end else begin
        ifc.in_valid = ($urandom_range(99) >= pct);
        if (bp_left == 0 && !ifc.out_ready) ifc.out_ready = 1'b1;
        if (!bp_done && bp_col >= 0 && ifc.out_valid && ifc.out_col == bp_col && ifc.out_row == 0) begin
          ifc.out_ready = 1'b0; bp_left = 5; bp_done = 1'b1;
        end
        if (bp_left > 0) begin
          #1;
          chk("bp_out_valid", ifc.out_valid, 1);
          chk("bp_out_col", ifc.out_col, bp_col);
          chk("bp_in_ready", ifc.in_ready, 0);
          chk("bp_win_clken", ifc.win_clken, 0);
          bp_left--;
        end
        if (ab_col >= 0 && ifc.out_valid && ifc.out_col == ab_col && ifc.out_row == 0) begin
          abort = 1'b1; ifc.in_valid = 1'b1;
          #1;
          chk("abort_win_clken", ifc.win_clken, 0);
          @(posedge clock); #1;
          abort = 1'b0; ifc.in_valid = 1'b0;
          chk("abort_busy", busy, 0);
          chk("abort_out_valid", ifc.out_valid, 0);
          chk("abort_row_done", row_done, 0);
          fin = 1'b1;
        end
        if (rs_col >= 0 && ifc.out_valid && ifc.out_col == rs_col && ifc.out_row == 1) begin
          #1; rst = 1'b1; #1;
          chk("rst_in_ready", ifc.in_ready, 0);
          chk("rst_win_clken", ifc.win_clken, 0);
          chk("rst_out_valid", ifc.out_valid, 0);
          chk("rst_out_col", ifc.out_col, 0);
          chk("rst_out_row", ifc.out_row, 0);
          chk("rst_row_done", row_done, 0);
          chk("rst_frame_done", frame_done, 0);
          chk("rst_busy", busy, 0);
          @(posedge clock); #1;
          rst = 1'b0; ifc.in_valid = 1'b0;
          fin = 1'b1;
        end
      end
    end
    if (!fin) chk("frame_timeout", frame_done, 1);
    start = 1'b0; abort = 1'b0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    @(negedge clock); #1;
  endtask

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("reset_in_ready", ifc.in_ready, 0);
    chk("reset_win_clken", ifc.win_clken, 0);
    chk("reset_out_valid", ifc.out_valid, 0);
    chk("reset_out_col", ifc.out_col, 0);
    chk("reset_out_row", ifc.out_row, 0);
    chk("reset_row_done", row_done, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    @(posedge clock); #1;
    ifc.in_valid = 1'b1;
    #1;
    chk("idle_in_ready", ifc.in_ready, 0);
    chk("idle_busy", busy, 0);
    ifc.in_valid = 1'b0;

    // Continuous stream with start pokes in RUN and GAP
    clr_stats();
    frame(0, -1, -1, -1, 1'b1);
    chk("cont_out_count", n_out, 2 * (W - D + 1));
    chk("cont_clken_count", n_clk, 2 * W);
    chk("cont_row_done", n_rd, 2);
    chk("cont_frame_done", n_fd, 1);
    chk("cont_gap", gap_len, G + 1);
    chk("cont_first_col", first_col, D - 1);
    chk("cont_first_row", first_row, 0);
    chk("cont_last_col", last_col, W - 1);
    chk("cont_sb_empty", sb_q.size(), 0);
    chk("cont_idle", busy, 0);

    // Backpressure held for 5 cycles at column 260
    clr_stats();
    frame(0, 260, -1, -1, 1'b0);
    chk("bp_out_count", n_out, 2 * (W - D + 1));
    chk("bp_clken_count", n_clk, 2 * W);
    chk("bp_frame_done", n_fd, 1);
    chk("bp_sb_empty", sb_q.size(), 0);

    // 30% in_valid holes
    clr_stats();
    frame(30, -1, -1, -1, 1'b0);
    chk("holes_out_count", n_out, 2 * (W - D + 1));
    chk("holes_clken_count", n_clk, 2 * W);
    chk("holes_first_col", first_col, D - 1);
    chk("holes_last_col", last_col, W - 1);
    chk("holes_frame_done", n_fd, 1);
    chk("holes_sb_empty", sb_q.size(), 0);

    // Abort at column 270 of row 0, then a fresh frame
    clr_stats();
    frame(0, -1, 270, -1, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    chk("abort_no_frame_done", n_fd, 0);
    chk("abort_still_idle", busy, 0);
    clr_stats();
    frame(0, -1, -1, -1, 1'b0);
    chk("post_abort_first_col", first_col, D - 1);
    chk("post_abort_first_row", first_row, 0);
    chk("post_abort_out_count", n_out, 2 * (W - D + 1));
    chk("post_abort_frame_done", n_fd, 1);

    // Async reset mid-row 1, then a full frame
    clr_stats();
    frame(0, -1, -1, 280, 1'b0);
    chk("rst_no_frame_done", n_fd, 0);
    clr_stats();
    frame(0, -1, -1, -1, 1'b0);
    chk("post_rst_frame_done", n_fd, 1);
    chk("post_rst_row_done", n_rd, 2);
    chk("post_rst_out_count", n_out, 2 * (W - D + 1));
    chk("post_rst_sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
